// File: rtl/soc_system_acc_pkg.sv
// Shared constants for the accelerator run controller: CSR map, bit positions, FSM states.
package soc_system_acc_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
  localparam logic [1:0] ADDR_CYCLES  = 2'd3;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_ABORT_BIT  = 2;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_TO_BIT   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/soc_system_acc_ctrl.sv
// Avalon-MM CSR slave sequencing one accelerator run: start pulse, done wait,
// cycle measurement, optional timeout abort and level interrupt.
module soc_system_acc_ctrl
  import soc_system_acc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        acc_start,
  output logic        acc_abort,
  input  logic        acc_done
);

  state_t             r_state;
  logic               r_irq_en;
  logic               r_done;
  logic               r_to_flag;
  logic               r_acc_abort;
  logic [CNT_W-1:0]   r_timeout;
  logic [CNT_W-1:0]   r_cycles;

  logic               w_wr;
  logic               w_ctrl_wr;
  logic               w_stat_wr;
  logic               w_to_wr;
  logic               w_start_req;
  logic               w_abort_req;
  logic [CNT_W-1:0]   w_cyc_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_wr        = chipselect & ~write_n;
  assign w_ctrl_wr   = w_wr && (address == ADDR_CTRL);
  assign w_stat_wr   = w_wr && (address == ADDR_STATUS);
  assign w_to_wr     = w_wr && (address == ADDR_TIMEOUT);
  assign w_start_req = w_ctrl_wr & writedata[CTRL_START_BIT] & ~writedata[CTRL_ABORT_BIT];
  assign w_abort_req = w_ctrl_wr & writedata[CTRL_ABORT_BIT];
  assign w_cyc_inc   = sat_inc(r_cycles);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_to_flag   <= 1'b0;
      r_acc_abort <= 1'b0;
      r_timeout   <= '0;
      r_cycles    <= '0;
    end else begin
      r_acc_abort <= 1'b0;
      if (w_ctrl_wr) r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
      if (w_to_wr) r_timeout <= writedata[CNT_W-1:0];
      // W1C first so that a flag set by the FSM below in the same cycle wins.
      if (w_stat_wr) begin
        if (writedata[STAT_DONE_BIT]) r_done <= 1'b0;
        if (writedata[STAT_TO_BIT]) r_to_flag <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start_req) begin
            r_state   <= S_START;
            r_cycles  <= '0;
            r_done    <= 1'b0;
            r_to_flag <= 1'b0;
          end
        end
        S_START: begin
          if (w_abort_req) begin
            r_state     <= S_IDLE;
            r_acc_abort <= 1'b1;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_cycles <= w_cyc_inc;
          if (acc_done) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (w_abort_req) begin
            r_state     <= S_IDLE;
            r_acc_abort <= 1'b1;
          end else if ((r_timeout != '0) && (w_cyc_inc == r_timeout)) begin
            r_state     <= S_IDLE;
            r_to_flag   <= 1'b1;
            r_acc_abort <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign acc_start = (r_state == S_START);
  assign acc_abort = r_acc_abort;
  assign irq       = r_irq_en & (r_done | r_to_flag);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:    readdata[CTRL_IRQ_EN_BIT] = r_irq_en;
      ADDR_STATUS: begin
        readdata[STAT_BUSY_BIT] = (r_state != S_IDLE);
        readdata[STAT_DONE_BIT] = r_done;
        readdata[STAT_TO_BIT]   = r_to_flag;
      end
      ADDR_TIMEOUT: readdata = 32'(r_timeout);
      ADDR_CYCLES:  readdata = 32'(r_cycles);
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_acc_ctrl.sv
// Scoreboard bench for soc_system_acc_ctrl: stimulus queues expected reads and pulses,
// a negedge monitor pops and compares whenever the DUT shows a read or pulse.
module tb_soc_system_acc_ctrl;

  localparam int K_READ  = 0;
  localparam int K_START = 1;
  localparam int K_ABORT = 2;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_TO   = 2'd2;
  localparam logic [1:0] A_CYC  = 2'd3;

  typedef struct {
    int          kind;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        acc_start;
  logic        acc_abort;
  logic        acc_done;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  soc_system_acc_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .acc_start (acc_start),
    .acc_abort (acc_abort),
    .acc_done  (acc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic observe(input int kind, input logic [1:0] a, input logic [31:0] d,
                         input logic i);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event kind=%0d addr=%0d data=0x%08h irq=%0b, none required",
               kind, a, d, i);
    end else begin
      e = q.pop_front();
      if (e.kind != kind ||
          (kind == K_READ && (e.addr != a || e.data !== d || e.irq !== i))) begin
        errors++;
        $display("FAIL %s: got kind=%0d addr=%0d data=0x%08h irq=%0b, required kind=%0d addr=%0d data=0x%08h irq=%0b",
                 e.name, kind, a, d, i, e.kind, e.addr, e.data, e.irq);
      end
    end
  endtask

  always @(negedge clk) begin
    if (acc_start === 1'b1) observe(K_START, 2'd0, 32'd0, 1'b0);
    if (acc_abort === 1'b1) observe(K_ABORT, 2'd0, 32'd0, 1'b0);
    if (chipselect === 1'b1 && write_n === 1'b1) observe(K_READ, address, readdata, irq);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    wait_cyc(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic exp_pulse(input int kind, input string nm);
    exp_t e;
    e.kind = kind; e.addr = 2'd0; e.data = '0; e.irq = 1'b0; e.name = nm;
    q.push_back(e);
  endtask

  task automatic exp_read(input logic [1:0] a, input logic [31:0] d, input logic i,
                          input string nm);
    exp_t e;
    e.kind = K_READ; e.addr = a; e.data = d; e.irq = i; e.name = nm;
    q.push_back(e);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    wait_cyc(1);
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
    writedata = '0; acc_done = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(1);

    // Reset state
    exp_read(A_CTRL, 32'h0, 1'b0, "rst_ctrl");
    exp_read(A_STAT, 32'h0, 1'b0, "rst_status");
    exp_read(A_TO,   32'h0, 1'b0, "rst_timeout");
    exp_read(A_CYC,  32'h0, 1'b0, "rst_cycles");

    // Done after 5 RUN cycles with IRQ enabled
    exp_pulse(K_START, "run5_start");
    bus_write(A_CTRL, 32'h3);
    wait_cyc(5);
    acc_done = 1'b1;
    wait_cyc(1);
    acc_done = 1'b0;
    exp_read(A_CYC,  32'd5, 1'b1, "run5_cycles");
    exp_read(A_STAT, 32'h2, 1'b1, "run5_status");
    exp_read(A_CTRL, 32'h2, 1'b1, "run5_ctrl");
    bus_write(A_STAT, 32'h2);
    exp_read(A_STAT, 32'h0, 1'b0, "run5_w1c");

    // Timeout with limit 8: exit on the 8th RUN edge
    bus_write(A_TO, 32'd8);
    exp_read(A_TO, 32'd8, 1'b0, "to8_reg");
    exp_pulse(K_START, "to8_start");
    bus_write(A_CTRL, 32'h1);
    wait_cyc(8);
    exp_read(A_STAT, 32'h1, 1'b0, "to8_busy_last");
    exp_pulse(K_ABORT, "to8_abort");
    exp_read(A_STAT, 32'h4, 1'b0, "to8_status");
    exp_read(A_CYC,  32'd8, 1'b0, "to8_cycles");
    bus_write(A_TO, 32'd0);

    // Second START while busy is ignored, then ABORT in RUN
    exp_pulse(K_START, "ab_start");
    bus_write(A_CTRL, 32'h1);
    wait_cyc(2);
    bus_write(A_CTRL, 32'h1);
    wait_cyc(2);
    exp_pulse(K_ABORT, "ab_abort");
    bus_write(A_CTRL, 32'h4);
    exp_read(A_STAT, 32'h0, 1'b0, "ab_status");
    exp_read(A_CYC,  32'd5, 1'b0, "ab_cycles");

    // acc_done and ABORT in the same RUN cycle: done wins, no abort pulse
    exp_pulse(K_START, "da_start");
    bus_write(A_CTRL, 32'h1);
    wait_cyc(2);
    acc_done = 1'b1;
    bus_write(A_CTRL, 32'h4);
    acc_done = 1'b0;
    exp_read(A_STAT, 32'h2, 1'b0, "da_status");
    exp_read(A_CYC,  32'd2, 1'b0, "da_cycles");

    // Timeout 3 with done on 3rd RUN cycle, plus a W1C of DONE on that same edge
    bus_write(A_TO, 32'd3);
    exp_pulse(K_START, "dt_start");
    bus_write(A_CTRL, 32'h3);
    wait_cyc(3);
    acc_done = 1'b1;
    bus_write(A_STAT, 32'h2);
    acc_done = 1'b0;
    exp_read(A_STAT, 32'h2, 1'b1, "dt_status");
    exp_read(A_CYC,  32'd3, 1'b1, "dt_cycles");
    bus_write(A_STAT, 32'h6);
    bus_write(A_TO, 32'd100);

    // One-cycle reset mid-RUN
    exp_pulse(K_START, "rr_start");
    bus_write(A_CTRL, 32'h3);
    wait_cyc(3);
    reset_n = 1'b0;
    wait_cyc(1);
    reset_n = 1'b1;
    exp_read(A_CTRL, 32'h0, 1'b0, "rr_ctrl");
    exp_read(A_STAT, 32'h0, 1'b0, "rr_status");
    exp_read(A_TO,   32'h0, 1'b0, "rr_timeout");
    exp_read(A_CYC,  32'h0, 1'b0, "rr_cycles");
    exp_pulse(K_START, "rr2_start");
    bus_write(A_CTRL, 32'h1);
    wait_cyc(4);
    acc_done = 1'b1;
    wait_cyc(1);
    acc_done = 1'b0;
    exp_read(A_STAT, 32'h2, 1'b0, "rr2_status");
    exp_read(A_CYC,  32'd4, 1'b0, "rr2_cycles");

    wait_cyc(3);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no event, required kind=%0d addr=%0d data=0x%08h",
               e.name, e.kind, e.addr, e.data);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
